// File: rtl/sumsub_arb_if.sv
// -----------------------------------------------------------------------------
// sumsub_arb_if
//   Bundle of the handshake and data signals between two requesters, the
//   sumsub_arb arbiter/sequencer and one result consumer.
//
//   Requester side (per port N = 0, 1):
//     reqN_valid  requester N has an operation pending
//     reqN_ready  requester N operation accepted this cycle
//     aN, bN      signed operands, WIDTH bits
//     opN         0 = a + b, 1 = a - b
//   Result side:
//     res_valid   result available
//     res_ready   consumer takes the result this cycle
//     res_id      index of the requester that issued the result
//     f           signed result, wraps modulo 2^WIDTH
//     ov          signed overflow of the operation
//
//   slave  : arbiter view (drives readys and the result)
//   master : environment view (drives requests and res_ready)
// -----------------------------------------------------------------------------
interface sumsub_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             op0;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             op1;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] f;
  logic             ov;

  modport slave (
    input  req0_valid, a0, b0, op0,
    input  req1_valid, a1, b1, op1,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, f, ov
  );

  modport master (
    output req0_valid, a0, b0, op0,
    output req1_valid, a1, b1, op1,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, f, ov
  );
endinterface

// File: rtl/sumsub_arb.sv
// -----------------------------------------------------------------------------
// sumsub_arb
//   Round-robin arbiter and sequencer for one shared WIDTH-bit two's-complement
//   adder/subtractor. One operation is in flight at a time:
//     IDLE : grant one valid requester, latch its a, b, op and id
//     CALC : run the latched operands through the add/sub unit, register
//            f, ov and res_id
//     RESP : hold the result with res_valid = 1 until res_ready
//
//   Ports:
//     clk    clock, all state updates on the rising edge
//     reset  synchronous, active-high; aborts any in-flight operation
//     bus    sumsub_arb_if.slave (two requesters + result port)
// -----------------------------------------------------------------------------
module sumsub_arb #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  sumsub_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Index of the requester served most recently; the other one wins a tie.
  logic             last_q, last_d;

  // Latched operation
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             id_q, id_d;

  // Registered result
  logic [WIDTH-1:0] f_q, f_d;
  logic             ov_q, ov_d;
  logic             res_id_q, res_id_d;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] sum_w;
  logic             ov_w;

  // ---------------------------------------------------------------------------
  // Arbitration: only in IDLE. A lone valid requester always wins; on a tie
  // the requester not served last wins, so a continuously valid pair
  // alternates. The two grants are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Shared add/sub unit. Overflow is judged from sign bits only:
  //   add: operands agree in sign and the result sign differs from them
  //   sub: operands differ in sign and the result sign differs from a
  // ---------------------------------------------------------------------------
  always_comb begin
    if (op_q) begin
      sum_w = a_q - b_q;
      ov_w  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      sum_w = a_q + b_q;
      ov_w  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    f_d      = f_q;
    ov_d     = ov_q;
    res_id_d = res_id_q;

    case (state_q)
      IDLE: begin
        // A grant implies valid, so a grant is exactly a transfer.
        if (grant0) begin
          a_d     = bus.a0;
          b_d     = bus.b0;
          op_d    = bus.op0;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = CALC;
        end else if (grant1) begin
          a_d     = bus.a1;
          b_d     = bus.b1;
          op_d    = bus.op1;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        f_d      = sum_w;
        ov_d     = ov_w;
        res_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last resets to 1 so requester 0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      id_q     <= 1'b0;
      f_q      <= '0;
      ov_q     <= 1'b0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      f_q      <= f_d;
      ov_q     <= ov_d;
      res_id_q <= res_id_d;
    end
  end

  assign bus.res_valid = (state_q == RESP);
  assign bus.f         = f_q;
  assign bus.ov        = ov_q;
  assign bus.res_id    = res_id_q;

endmodule
